led_bank_arbiter: RTL and testbench
===================================

# led_bank_arbiter

Time-shares the 4-LED board bank among `NUM_REQ` requesters: CPU status, fault flag, debug. Uses round-robin arbitration with a guaranteed minimum display time per grant. When no requester is active, the bank falls back to the free-running heartbeat counter, so the board always blinks. Sits between the top level's LED pins and the blinker counter.

## Interface
- `NUM_REQ`, 3, number of requesters (2..8)
- `HOLD_CYCLES`, 1_000_000, minimum grant duration in clocks (≥2)
- `HB_BIT`, 18, lowest `Counter` bit shown on the LEDs in idle
- `Clock`  in  1  single clock domain
- `Reset`  in  1  synchronous, active-low
- `Counter`  in  32  free-running heartbeat counter
- `Req`  in  NUM_REQ  per-requester level request
- `Pattern`  in  4*NUM_REQ  requester i drives bits [4i+3:4i]
- `Grant`  out  NUM_REQ  one-hot owner, or all zero
- `Busy`  out  1  high when not IDLE
- `LED`  out  4  registered LED drive

## Operation
- States:
  - IDLE: no owner.
  - HOLD: owner granted, hold timer running.
  - OWNED: hold expired, owner still requesting, nobody else pending.
- IDLE:
  - LED <= Counter[HB_BIT+3:HB_BIT].
  - If any Req, pick the winner, load timer = HOLD_CYCLES-1, latch Pattern[winner], go to HOLD.
- HOLD:
  - Timer decrements each cycle.
  - While Req[owner]=1, latch is refreshed from the live Pattern[owner].
  - If Req[owner] drops, latch freezes at the last value; the grant persists until the timer reaches 0.
  - LED <= latch.
- Timer reaches 0 (the HOLD cycle with timer==0), next state:
  - Another Req pending → new winner, reload timer, stay HOLD. Preempts the owner even if it still requests.
  - Else Req[owner]=1 → OWNED.
  - Else → IDLE.
- OWNED:
  - Live pattern follows Req[owner].
  - Another Req asserts → switch to new winner in HOLD.
  - Req[owner] drops with no other pending → IDLE.
- Round-robin:
  - Search starts at index ptr, ascending mod NUM_REQ; first set Req (excluding current owner at preemption) wins.
  - ptr <= winner+1 mod NUM_REQ on every grant.
- Grant is one-hot registered, updated on the same edge as the state.
- Busy = (state != IDLE).

## Timing
- Reset (Reset=0 at rising edge):
  - state IDLE, Grant=0, Busy=0, LED=0, ptr=0, timer=0, latch=0.
  - Takes effect mid-grant: owner loses the bank the next cycle, no hold honoured.
- Req high at edge N in IDLE → Grant/Busy high after edge N. LED shows the pattern after edge N+1 (one extra register stage).
- Pattern change by the owner → visible on LED 2 edges later.
- Grant lasts at least HOLD_CYCLES clocks, even if Req pulses for a single cycle.
- Handover is back-to-back: old Grant falls and new Grant rises on the same edge; no IDLE cycle is inserted.
- Simultaneous requests in IDLE resolve by ptr; after reset, index 0 wins.
- Timer width is $clog2(HOLD_CYCLES); it never underflows and holds at 0 outside HOLD.
- Idle LED follows Counter with one register of latency.

## Structure
- Package `led_arb_pkg`:
  - state enum {IDLE, HOLD, OWNED}
  - `LED_W`=4
  - function onehot_to_index
- Sub-module `led_rr_picker`: combinational round-robin.
  - Inputs: req, ptr, mask.
  - Outputs: valid, index.
  - Reusable for other shared board resources.
- Top-level integration drives LED1..LED4 from `LED`. Reset at the pin is active-high, so it is inverted before this block, which takes active-low.

## Test plan
- Reset held, then released with Req=0, Counter=0x003C0000 (bits 21:18 = 4'hF) → Grant=0, Busy=0, LED=4'hF one cycle later.
- Req=3'b001 for one cycle, Pattern0=4'hA, HOLD_CYCLES=8 → Grant=001 for exactly 8 cycles, LED=4'hA, then IDLE.
- Req=3'b111 held, Patterns 1/2/4 → grants rotate 001→010→100→001 every 8 cycles, LED follows, no idle gaps.
- Req0 held alone past expiry → OWNED. Req2 rises → Grant=100 on the next edge, HOLD restarted.
- Mid-HOLD Reset=0 for one edge → Grant=0, LED=0, ptr=0 next cycle. Re-request from Req1 → granted after one cycle.
- Owner drops Req in the exact cycle the timer reaches 0 while Req1 rises → Grant moves directly to 010, Busy stays 1.

Source files
------------

// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED bank arbiter and its round-robin picker.
package led_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        OWNED = 2'd2
    } arb_state_e;

    localparam int LED_W   = 4;
    localparam int MAX_REQ = 8;

    // Converts a one-hot owner vector (up to MAX_REQ wide) into a binary index.
    function automatic logic [2:0] onehot_to_index(input logic [MAX_REQ-1:0] onehot);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/led_rr_picker.sv
// Combinational round-robin picker: first unmasked request at or after ptr wins.
module led_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    logic [NUM_REQ-1:0] cand_s;

    assign cand_s = req & ~mask;

    // Scan candidates in ascending order starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin : scan
        int          pos;
        logic [IDX_W-1:0] pos_idx;
        valid   = 1'b0;
        index   = '0;
        pos     = 0;
        pos_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end else begin
                pos = pos;
            end
            pos_idx = IDX_W'(pos);
            if (!valid && cand_s[pos_idx]) begin
                valid = 1'b1;
                index = pos_idx;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/led_bank_arbiter.sv
// Time-shares the 4-LED bank among NUM_REQ requesters with a minimum hold per
// grant; shows the heartbeat counter when nobody owns the bank.
module led_bank_arbiter
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int HOLD_CYCLES = 1_000_000,
    parameter int HB_BIT      = 18
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [31:0]              Counter,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [LED_W*NUM_REQ-1:0] Pattern,
    output logic [NUM_REQ-1:0]       Grant,
    output logic                     Busy,
    output logic [LED_W-1:0]         LED
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(HOLD_CYCLES);
    localparam logic [TW-1:0]      TIMER_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_e         state_r, state_nxt_s;
    logic [TW-1:0]      timer_r, timer_nxt_s;
    logic [LED_W-1:0]   latch_r, latch_nxt_s;
    logic [LED_W-1:0]   led_r, led_nxt_s;
    logic [NUM_REQ-1:0] grant_r, grant_nxt_s;
    logic [IW-1:0]      ptr_r, ptr_nxt_s;
    logic               busy_r;

    logic [2:0]         owner_full_s;
    logic [IW-1:0]      owner_idx_s;
    logic               owner_req_s;
    logic               pick_valid_s;
    logic [IW-1:0]      pick_idx_s;
    logic [LED_W-1:0]   owner_pat_s;
    logic [LED_W-1:0]   pick_pat_s;
    logic               take_s;
    logic               unused_bits_s;

    assign owner_full_s  = onehot_to_index(MAX_REQ'(grant_r));
    assign owner_idx_s   = owner_full_s[IW-1:0];
    assign owner_req_s   = (grant_r != '0) && Req[owner_idx_s];
    assign unused_bits_s = ^{Counter, owner_full_s};

    // The current owner is masked so that an expiry or OWNED-state search
    // only finds other requesters; in IDLE grant_r is zero so nothing is masked.
    led_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_picker (
        .req   (Req),
        .ptr   (ptr_r),
        .mask  (grant_r),
        .valid (pick_valid_s),
        .index (pick_idx_s)
    );

    // Select the owner's and the winner's pattern nibbles.
    always_comb begin
        owner_pat_s = '0;
        pick_pat_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == owner_idx_s) begin
                owner_pat_s = Pattern[i*LED_W +: LED_W];
            end else begin
                owner_pat_s = owner_pat_s;
            end
            if (IW'(i) == pick_idx_s) begin
                pick_pat_s = Pattern[i*LED_W +: LED_W];
            end else begin
                pick_pat_s = pick_pat_s;
            end
        end
    end

    // Next-state, hold timer, pattern latch, grant, pointer and LED selection.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        latch_nxt_s = latch_r;
        grant_nxt_s = grant_r;
        ptr_nxt_s   = ptr_r;
        led_nxt_s   = latch_r;
        take_s      = 1'b0;
        case (state_r)
            IDLE: begin
                led_nxt_s   = Counter[HB_BIT+LED_W-1:HB_BIT];
                timer_nxt_s = '0;
                grant_nxt_s = '0;
                take_s      = pick_valid_s;
            end
            HOLD: begin
                if (owner_req_s) begin
                    latch_nxt_s = owner_pat_s;
                end else begin
                    latch_nxt_s = latch_r;
                end
                if (timer_r == '0) begin
                    if (pick_valid_s) begin
                        take_s = 1'b1;
                    end else if (owner_req_s) begin
                        state_nxt_s = OWNED;
                    end else begin
                        state_nxt_s = IDLE;
                        grant_nxt_s = '0;
                    end
                end else begin
                    timer_nxt_s = timer_r - TW'(1);
                end
            end
            OWNED: begin
                if (owner_req_s) begin
                    latch_nxt_s = owner_pat_s;
                end else begin
                    latch_nxt_s = latch_r;
                end
                if (pick_valid_s) begin
                    take_s = 1'b1;
                end else if (!owner_req_s) begin
                    state_nxt_s = IDLE;
                    grant_nxt_s = '0;
                end else begin
                    state_nxt_s = OWNED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = '0;
                timer_nxt_s = '0;
            end
        endcase
        if (take_s) begin
            state_nxt_s = HOLD;
            timer_nxt_s = TIMER_LOAD;
            latch_nxt_s = pick_pat_s;
            grant_nxt_s = ONE_HOT0 << pick_idx_s;
            if (pick_idx_s == IW'(NUM_REQ - 1)) begin
                ptr_nxt_s = '0;
            end else begin
                ptr_nxt_s = pick_idx_s + IW'(1);
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_r <= IDLE;
            timer_r <= '0;
            latch_r <= '0;
            led_r   <= '0;
            grant_r <= '0;
            ptr_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            latch_r <= latch_nxt_s;
            led_r   <= led_nxt_s;
            grant_r <= grant_nxt_s;
            ptr_r   <= ptr_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    assign Grant = grant_r;
    assign Busy  = busy_r;
    assign LED   = led_r;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboard bench for led_bank_arbiter: the driver queues the expected
// Grant/Busy/LED for each edge it drives, a monitor compares after each edge.
module tb_led_bank_arbiter;

    localparam int NUM_REQ     = 3;
    localparam int HOLD_CYCLES = 8;
    localparam int HB_BIT      = 18;

    typedef struct {
        int         cyc;
        logic [2:0] grant;
        logic       busy;
        logic [3:0] led;
        string      name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] counter;
    logic [2:0]  req;
    logic [11:0] pattern;
    logic [2:0]  grant;
    logic        busy;
    logic [3:0]  led;

    exp_t exp_q[$];
    int   cyc_cnt;
    int   n_cmp;
    int   n_bad;

    led_bank_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .HOLD_CYCLES (HOLD_CYCLES),
        .HB_BIT      (HB_BIT)
    ) dut (
        .Clock   (clk),
        .Reset   (rst_n),
        .Counter (counter),
        .Req     (req),
        .Pattern (pattern),
        .Grant   (grant),
        .Busy    (busy),
        .LED     (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: after each rising edge, compare against the entry queued for it.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: entry for cycle %0d never checked (now %0d)", e.name, e.cyc, cyc_cnt);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (grant !== e.grant || busy !== e.busy || led !== e.led) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: got grant=%b busy=%b led=%h, expected grant=%b busy=%b led=%h",
                         e.name, cyc_cnt, grant, busy, led, e.grant, e.busy, e.led);
            end
        end
    end

    // Drive inputs for the next edge and queue what the outputs must be after it.
    task automatic step(input logic rst_v, input logic [2:0] r, input logic [2:0] eg,
                        input logic eb, input logic [3:0] el, input string nm);
        exp_t e;
        rst_n   = rst_v;
        req     = r;
        e.cyc   = cyc_cnt + 1;
        e.grant = eg;
        e.busy  = eb;
        e.led   = el;
        e.name  = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] g;
        logic [3:0] prev;
        logic [3:0] cur;
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        req     = 3'b000;
        counter = 32'h003C_0000;
        pattern = 12'h000;
        @(posedge clk);
        #1;

        // Reset and idle heartbeat display
        step(1'b0, 3'b000, 3'b000, 1'b0, 4'h0, "reset");
        step(1'b0, 3'b000, 3'b000, 1'b0, 4'h0, "reset");
        step(1'b1, 3'b000, 3'b000, 1'b0, 4'hF, "idle_heartbeat");
        step(1'b1, 3'b000, 3'b000, 1'b0, 4'hF, "idle_heartbeat");

        // Single-cycle pulse from requester 0 still gets the full hold
        pattern = 12'h00A;
        step(1'b1, 3'b001, 3'b001, 1'b1, 4'hF, "pulse_grant");
        for (int k = 0; k < 7; k++) step(1'b1, 3'b000, 3'b001, 1'b1, 4'hA, "pulse_hold");
        step(1'b1, 3'b000, 3'b000, 1'b0, 4'hA, "pulse_expire");
        step(1'b1, 3'b000, 3'b000, 1'b0, 4'hF, "pulse_idle_led");

        // Re-reset so the pointer starts at 0, then all three request together
        step(1'b0, 3'b000, 3'b000, 1'b0, 4'h0, "reset_ptr");
        step(1'b1, 3'b000, 3'b000, 1'b0, 4'hF, "idle_again");
        pattern = 12'h421;
        prev = 4'hF;
        for (int r = 0; r < 3; r++) begin
            g   = 3'b001 << r;
            cur = 4'h1 << r;
            step(1'b1, 3'b111, g, 1'b1, prev, "rotate_switch");
            for (int k = 0; k < 7; k++) step(1'b1, 3'b111, g, 1'b1, cur, "rotate_hold");
            prev = cur;
        end
        step(1'b1, 3'b111, 3'b001, 1'b1, 4'h4, "rotate_wrap");

        // Requester 0 alone past expiry enters OWNED, live pattern followed
        for (int k = 0; k < 7; k++) step(1'b1, 3'b001, 3'b001, 1'b1, 4'h1, "solo_hold");
        step(1'b1, 3'b001, 3'b001, 1'b1, 4'h1, "owned_enter");
        step(1'b1, 3'b001, 3'b001, 1'b1, 4'h1, "owned");
        pattern = 12'h427;
        step(1'b1, 3'b001, 3'b001, 1'b1, 4'h1, "owned_latch");
        step(1'b1, 3'b001, 3'b001, 1'b1, 4'h7, "owned_live");

        // Requester 2 preempts OWNED at once and gets a fresh full hold
        step(1'b1, 3'b101, 3'b100, 1'b1, 4'h7, "preempt");
        for (int k = 0; k < 7; k++) step(1'b1, 3'b101, 3'b100, 1'b1, 4'h4, "hold_restart");
        step(1'b1, 3'b101, 3'b001, 1'b1, 4'h4, "restart_expiry");
        step(1'b1, 3'b101, 3'b001, 1'b1, 4'h7, "back_to_0");

        // Mid-hold reset drops the owner immediately; requester 1 re-grants
        step(1'b0, 3'b000, 3'b000, 1'b0, 4'h0, "reset_mid");
        step(1'b1, 3'b010, 3'b010, 1'b1, 4'hF, "regrant");
        for (int k = 0; k < 7; k++) step(1'b1, 3'b010, 3'b010, 1'b1, 4'h2, "regrant_hold");

        // Owner drops exactly at expiry while another rises: direct handover
        step(1'b1, 3'b100, 3'b100, 1'b1, 4'h2, "drop_handover_2");
        for (int k = 0; k < 7; k++) step(1'b1, 3'b100, 3'b100, 1'b1, 4'h4, "hold_2");
        step(1'b1, 3'b010, 3'b010, 1'b1, 4'h4, "drop_handover_1");
        for (int k = 0; k < 7; k++) step(1'b1, 3'b000, 3'b010, 1'b1, 4'h2, "hold_after_drop");
        step(1'b1, 3'b000, 3'b000, 1'b0, 4'h2, "expire_idle");
        step(1'b1, 3'b000, 3'b000, 1'b0, 4'hF, "idle_led");
        counter = 32'h0014_0000;
        step(1'b1, 3'b000, 3'b000, 1'b0, 4'h5, "counter_follow");

        // Bounded drain of the scoreboard
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
